// File: rtl/accum_pkg.sv
// Shared types for the shift-accumulate capture path: RAM request kinds and
// the scan controller state encoding.
package accum_pkg;

    typedef enum logic [1:0] {
        ACC_READ       = 2'd0,
        ACC_WRITE      = 2'd1,
        ACC_WRITE_OVER = 2'd2,
        ACC_DISABLE    = 2'd3
    } accum_request_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_READOUT,
        ST_FLUSH
    } scan_state_t;

endpackage

// File: rtl/accum_scan_ctrl_if.sv
// Pixel stream, accumulator-RAM request/echo and code readout bundle of the
// scan controller; master is the controller, slave is its environment.
interface accum_scan_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
);
    import accum_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic             start_in;
    logic             abort_in;
    logic             pix_valid_in;
    logic             pix_bit_in;
    logic             pix_kill_in;
    logic             pix_ready_out;

    logic [AW-1:0]    ram_addr_out;
    logic             ram_summand_out;
    accum_request_t   ram_req_type_out;
    logic             ram_req_valid_out;

    logic [WIDTH-1:0] ram_read_in;
    logic [AW-1:0]    ram_addr_in;
    accum_request_t   ram_req_type_in;
    logic             ram_valid_in;

    logic             code_valid_out;
    logic [AW-1:0]    code_addr_out;
    logic [WIDTH-1:0] code_out;
    logic             busy_out;
    logic             done_out;

    modport master (
        input  start_in, abort_in, pix_valid_in, pix_bit_in, pix_kill_in,
        input  ram_read_in, ram_addr_in, ram_req_type_in, ram_valid_in,
        output pix_ready_out, ram_addr_out, ram_summand_out, ram_req_type_out,
        output ram_req_valid_out, code_valid_out, code_addr_out, code_out,
        output busy_out, done_out
    );

    modport slave (
        output start_in, abort_in, pix_valid_in, pix_bit_in, pix_kill_in,
        output ram_read_in, ram_addr_in, ram_req_type_in, ram_valid_in,
        input  pix_ready_out, ram_addr_out, ram_summand_out, ram_req_type_out,
        input  ram_req_valid_out, code_valid_out, code_addr_out, code_out,
        input  busy_out, done_out
    );

endinterface

// File: rtl/accum_scan_ctrl.sv
// Sequences WIDTH capture frames into a shift-accumulate RAM, then reads every
// pixel code back out once the last write has landed.
module accum_scan_ctrl
    import accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    accum_scan_ctrl_if.master bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(WIDTH);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(WIDTH - 1);

    // Assert asynchronously, release two clocks after rst_n_in rises.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n_sync;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_sync = rst_sync_q[1];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rst_sync_q <= '0;
        else           rst_sync_q <= rst_sync_d;
    end

    scan_state_t   state_q, state_d;
    logic [AW-1:0] pix_addr_q, pix_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          wait_cnt_q, wait_cnt_d;
    logic          done_q, done_d;
    logic          beat;

    assign beat = (state_q == ST_CAPTURE) && bus.pix_valid_in && !bus.abort_in;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pix_addr_d  = pix_addr_q;
        rd_addr_d   = rd_addr_q;
        frame_cnt_d = frame_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: if (bus.start_in) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (beat) begin
                    if (pix_addr_q == ADDR_LAST) begin
                        pix_addr_d = '0;
                        if (frame_cnt_q == FRAME_LAST) begin
                            frame_cnt_d = '0;
                            state_d     = ST_DRAIN;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FW'(1);
                        end
                    end else begin
                        pix_addr_d = pix_addr_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                wait_cnt_d = ~wait_cnt_q;
                if (wait_cnt_q) state_d = ST_READOUT;
            end
            ST_READOUT: begin
                if (rd_addr_q == ADDR_LAST) begin
                    rd_addr_d = '0;
                    state_d   = ST_FLUSH;
                end else begin
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            ST_FLUSH: begin
                wait_cnt_d = ~wait_cnt_q;
                if (wait_cnt_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.abort_in) begin
            state_d     = ST_IDLE;
            pix_addr_d  = '0;
            rd_addr_d   = '0;
            frame_cnt_d = '0;
            wait_cnt_d  = 1'b0;
            done_d      = 1'b0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk_in or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q     <= ST_IDLE;
            pix_addr_q  <= '0;
            rd_addr_q   <= '0;
            frame_cnt_q <= '0;
            wait_cnt_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_addr_q  <= pix_addr_d;
            rd_addr_q   <= rd_addr_d;
            frame_cnt_q <= frame_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            done_q      <= done_d;
        end
    end

    // Requests go out in the same cycle as the accepted beat; idle fields stay 0.
    always_comb begin
        bus.ram_req_valid_out = 1'b0;
        bus.ram_addr_out      = '0;
        bus.ram_summand_out   = 1'b0;
        bus.ram_req_type_out  = ACC_READ;
        if (beat) begin
            bus.ram_req_valid_out = 1'b1;
            bus.ram_addr_out      = pix_addr_q;
            bus.ram_summand_out   = bus.pix_bit_in;
            if (bus.pix_kill_in)         bus.ram_req_type_out = ACC_DISABLE;
            else if (frame_cnt_q == '0)  bus.ram_req_type_out = ACC_WRITE_OVER;
            else                         bus.ram_req_type_out = ACC_WRITE;
        end else if (state_q == ST_READOUT && !bus.abort_in) begin
            bus.ram_req_valid_out = 1'b1;
            bus.ram_addr_out      = rd_addr_q;
        end
    end

    assign bus.pix_ready_out  = (state_q == ST_CAPTURE) && !bus.abort_in;
    assign bus.busy_out       = (state_q != ST_IDLE);
    assign bus.done_out       = done_q;

    // Locked-out pixels read back as all-ones and are passed through untouched.
    assign bus.code_valid_out = bus.ram_valid_in && (bus.ram_req_type_in == ACC_READ);
    assign bus.code_addr_out  = bus.ram_addr_in;
    assign bus.code_out       = bus.ram_read_in;

endmodule

// File: tb/tb_accum_scan_ctrl.sv
// Bench for accum_scan_ctrl with a behavioural shift-accumulate RAM beside it;
// codes are predicted from the per-frame pixel bits and kill marks.
module tb_accum_scan_ctrl;
    import accum_pkg::*;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int AW = $clog2(D);

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b1;
    always #5 clk_in = ~clk_in;

    accum_scan_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();

    accum_scan_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    // RAM model: 2-cycle request echo; writes commit when the echo emerges.
    logic [W-1:0]   mem [D];
    logic           prefill     = 1'b0;
    logic [W-1:0]   prefill_val = '0;
    logic           s1_v, s2_v, s1_s, s2_s;
    logic [AW-1:0]  s1_a, s2_a;
    accum_request_t s1_t, s2_t;
    logic [W-1:0]   s1_d, s2_d;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_v <= 1'b0; s2_v <= 1'b0; s1_s <= 1'b0; s2_s <= 1'b0;
            s1_a <= '0;   s2_a <= '0;   s1_t <= ACC_READ; s2_t <= ACC_READ;
            s1_d <= '0;   s2_d <= '0;
        end else begin
            s1_v <= bus.ram_req_valid_out;
            s1_a <= bus.ram_addr_out;
            s1_t <= bus.ram_req_type_out;
            s1_s <= bus.ram_summand_out;
            s1_d <= mem[bus.ram_addr_out];
            s2_v <= s1_v; s2_a <= s1_a; s2_t <= s1_t; s2_s <= s1_s; s2_d <= s1_d;
        end
    end

    always @(posedge clk_in) begin
        if (prefill) begin
            for (int i = 0; i < D; i++) mem[i] <= prefill_val;
        end else if (s2_v) begin
            case (s2_t)
                ACC_WRITE_OVER: mem[s2_a] <= {{(W-1){1'b0}}, s2_s};
                ACC_WRITE:      if (mem[s2_a] != '1) mem[s2_a] <= {mem[s2_a][W-2:0], s2_s};
                ACC_DISABLE:    mem[s2_a] <= '1;
                default: ;
            endcase
        end
    end

    assign bus.ram_valid_in    = s2_v;
    assign bus.ram_addr_in     = s2_a;
    assign bus.ram_req_type_in = s2_t;
    assign bus.ram_read_in     = s2_d;

    // Monitor
    int n_wr = 0, n_rd = 0, n_done = 0, n_dirty = 0;
    logic [AW-1:0] got_addr [$];
    logic [W-1:0]  got_code [$];

    always @(negedge clk_in) begin
        if (bus.code_valid_out) begin
            got_addr.push_back(bus.code_addr_out);
            got_code.push_back(bus.code_out);
        end
        if (bus.ram_req_valid_out) begin
            if (bus.ram_req_type_out == ACC_READ) n_rd++;
            else                                  n_wr++;
        end else if (bus.ram_addr_out != '0 || bus.ram_summand_out || bus.ram_req_type_out != ACC_READ) begin
            n_dirty++;
        end
        if (bus.done_out) n_done++;
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    logic pix_bits [W][D];
    logic pix_kill [W][D];

    function automatic logic [W-1:0] model_code(input int p);
        int v;
        v = 0;
        for (int f = 0; f < W; f++) begin
            if (pix_kill[f][p]) return '1;
            v = v * 2 + int'(pix_bits[f][p]);
        end
        return W'(v);
    endfunction

    typedef struct {
        string        name;
        logic [W-1:0] frame_bits;  // bit W-1 is frame 0
        int           kill_pix;
        int           kill_frame;
        bit           gaps;
        bit           stale;
        logic [W-1:0] exp_norm;
        logic [W-1:0] exp_kill;
        int           exp_wr;
        int           exp_rd;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [W-1:0] fb, input int kp, input int kf,
                                input bit g, input bit s, input logic [W-1:0] en, input logic [W-1:0] ek);
        vec_t v;
        v.name = n; v.frame_bits = fb; v.kill_pix = kp; v.kill_frame = kf;
        v.gaps = g; v.stale = s; v.exp_norm = en; v.exp_kill = ek;
        v.exp_wr = W * D; v.exp_rd = D;
        return v;
    endfunction

    task automatic do_prefill(input logic [W-1:0] v);
        @(posedge clk_in); #1;
        prefill_val = v; prefill = 1'b1;
        @(posedge clk_in); #1;
        prefill = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk_in); #1;
        bus.start_in = 1'b1;
        @(posedge clk_in); #1;
        bus.start_in = 1'b0;
    endtask

    task automatic drive_frames(input bit gaps, input int abort_f, input int abort_p);
        int f, p, guard;
        logic rdy;
        f = 0; p = 0; guard = 0;
        do_start();
        while (f < W && guard < 2000) begin
            guard++;
            if (gaps && $urandom_range(1, 0) == 0) begin
                bus.pix_valid_in = 1'b0;
                @(posedge clk_in); #1;
                continue;
            end
            bus.pix_valid_in = 1'b1;
            bus.pix_bit_in   = pix_bits[f][p];
            bus.pix_kill_in  = pix_kill[f][p];
            if (f == abort_f && p == abort_p) begin
                bus.abort_in = 1'b1;
                @(posedge clk_in); #1;
                bus.abort_in = 1'b0; bus.pix_valid_in = 1'b0; bus.pix_kill_in = 1'b0;
                return;
            end
            @(negedge clk_in);
            rdy = bus.pix_ready_out;
            @(posedge clk_in); #1;
            if (rdy) begin
                p++;
                if (p == D) begin p = 0; f++; end
            end
        end
        bus.pix_valid_in = 1'b0; bus.pix_kill_in = 1'b0; bus.pix_bit_in = 1'b0;
        check("capture_bound", guard < 2000, 1);
    endtask

    task automatic wait_done(input int base_d);
        int c;
        c = 0;
        while (n_done == base_d && c < 300) begin
            @(posedge clk_in); #1;
            c++;
        end
        check("done_seen", n_done != base_d, 1);
        repeat (5) @(posedge clk_in);
        #1;
        check("done_pulses", n_done - base_d, 1);
    endtask

    task automatic check_codes(input int base, input bit use_tab, input logic [W-1:0] e_norm,
                               input logic [W-1:0] e_kill, input int kp);
        check("code_count", got_code.size() - base, D);
        for (int i = 0; i < D && base + i < got_code.size(); i++) begin
            logic [W-1:0] e;
            e = use_tab ? ((i == kp) ? e_kill : e_norm) : model_code(i);
            check($sformatf("code_addr[%0d]", i), got_addr[base + i], i);
            check($sformatf("code[%0d]", i), got_code[base + i], e);
        end
    endtask

    task automatic randomize_pixels(input bit with_kill);
        for (int f = 0; f < W; f++)
            for (int p = 0; p < D; p++) begin
                pix_bits[f][p] = 1'($urandom_range(1, 0));
                pix_kill[f][p] = with_kill && ($urandom_range(15, 0) == 0);
            end
    endtask

    task automatic random_run(input bit gaps, input bit kills, input bit poke_start);
        int bc, bw, br, bd;
        randomize_pixels(kills);
        bc = got_code.size(); bw = n_wr; br = n_rd; bd = n_done;
        drive_frames(gaps, -1, -1);
        if (poke_start) begin
            bus.start_in = 1'b1;
            @(posedge clk_in); #1;
            bus.start_in = 1'b0;
        end
        wait_done(bd);
        check_codes(bc, 1'b0, '0, '0, -1);
        check("rand_writes", n_wr - bw, W * D);
        check("rand_reads", n_rd - br, D);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tab [4];
        int bc, bw, br, bd, c;

        tab[0] = mk("pattern_1011", 4'b1011, -1, -1, 1'b0, 1'b0, 4'b1011, 4'b1011);
        tab[1] = mk("kill_p3_f2",   4'b1011,  3,  2, 1'b0, 1'b0, 4'b1011, 4'b1111);
        tab[2] = mk("stale_clear",  4'b0000, -1, -1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        tab[3] = mk("gaps_1011",    4'b1011, -1, -1, 1'b1, 1'b0, 4'b1011, 4'b1011);

        bus.start_in = 1'b0; bus.abort_in = 1'b0;
        bus.pix_valid_in = 1'b0; bus.pix_bit_in = 1'b0; bus.pix_kill_in = 1'b0;

        #1 rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_busy", bus.busy_out, 0);
        check("rst_ready", bus.pix_ready_out, 0);
        check("rst_req_valid", bus.ram_req_valid_out, 0);
        check("rst_done", bus.done_out, 0);
        check("rst_code_valid", bus.code_valid_out, 0);
        #1 rst_n_in = 1'b1;
        do_prefill('0);
        repeat (4) @(posedge clk_in);
        #1;

        // start and abort together in IDLE: abort wins
        bus.start_in = 1'b1; bus.abort_in = 1'b1;
        @(posedge clk_in); #1;
        bus.start_in = 1'b0; bus.abort_in = 1'b0;
        @(negedge clk_in);
        check("start_abort_idle", bus.busy_out, 0);
        @(posedge clk_in); #1;

        for (int t = 0; t < 4; t++) begin
            for (int f = 0; f < W; f++)
                for (int p = 0; p < D; p++) begin
                    pix_bits[f][p] = tab[t].frame_bits[W-1-f];
                    pix_kill[f][p] = (p == tab[t].kill_pix) && (f == tab[t].kill_frame);
                end
            if (tab[t].stale) do_prefill('1);
            bc = got_code.size(); bw = n_wr; br = n_rd; bd = n_done;
            drive_frames(tab[t].gaps, -1, -1);
            wait_done(bd);
            check_codes(bc, 1'b1, tab[t].exp_norm, tab[t].exp_kill, tab[t].kill_pix);
            check({tab[t].name, "_writes"}, n_wr - bw, tab[t].exp_wr);
            check({tab[t].name, "_reads"}, n_rd - br, tab[t].exp_rd);
        end

        random_run(1'b0, 1'b1, 1'b1);
        random_run(1'b1, 1'b1, 1'b0);
        random_run(1'b1, 1'b0, 1'b1);

        // abort during frame 1 pixel 5
        randomize_pixels(1'b0);
        bd = n_done;
        drive_frames(1'b0, 1, 5);
        bw = n_wr; br = n_rd;
        @(negedge clk_in);
        check("abort_idle", bus.busy_out, 0);
        check("abort_ready", bus.pix_ready_out, 0);
        repeat (20) @(posedge clk_in);
        #1;
        check("abort_no_requests", (n_wr - bw) + (n_rd - br), 0);
        check("abort_no_done", n_done - bd, 0);
        random_run(1'b0, 1'b0, 1'b0);

        // reset asserted during readout
        randomize_pixels(1'b0);
        br = n_rd;
        drive_frames(1'b0, -1, -1);
        c = 0;
        while (n_rd == br && c < 100) begin
            @(posedge clk_in); #1;
            c++;
        end
        check("readout_reached", n_rd != br, 1);
        #2 rst_n_in = 1'b0;
        #1;
        check("midrst_busy", bus.busy_out, 0);
        check("midrst_req_valid", bus.ram_req_valid_out, 0);
        check("midrst_ready", bus.pix_ready_out, 0);
        check("midrst_done", bus.done_out, 0);
        repeat (3) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        repeat (10) @(posedge clk_in);
        #1;
        check("postrst_busy", bus.busy_out, 0);
        random_run(1'b1, 1'b1, 1'b0);

        check("idle_fields_zero", n_dirty, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
